// File: rtl/acc_pkg.sv
// acc_pkg: shared state encoding and default widths for the accumulator sequencer
package acc_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int COUNT_W_DEF = 4;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/acc_reg.sv
// acc_reg: accumulator register with async reset, sync clear and load enable
module acc_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/accumulator_ctrl.sv
// accumulator_ctrl: sequences clear/accumulate/result handshake for the accumulator datapath
module accumulator_ctrl
  import acc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   acc_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic               overflow
);
  state_t state;
  logic [COUNT_W-1:0] count;
  logic [WIDTH:0] sum;
  logic xfer, clr;
  assign in_ready = state == ST_ACCUM;
  assign res_valid = state == ST_DONE;
  assign busy = state != ST_IDLE;
  assign xfer = in_ready && in_valid;
  assign clr = state == ST_IDLE && start;
  // Gate the operand so an undriven in_data never reaches the adder
  assign sum = {1'b0, acc_out} + {1'b0, xfer ? in_data : '0};
  acc_reg #(.WIDTH(WIDTH)) u_acc (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en(xfer),
    .d(sum[WIDTH-1:0]),
    .q(acc_out)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      overflow <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        overflow <= 1'b0;
        count <= len;
        state <= len != '0 ? ST_ACCUM : ST_DONE;
      end
    end else if (state == ST_ACCUM) begin
      if (in_valid) begin
        overflow <= overflow | sum[WIDTH];
        count <= count - 1'b1;
        if (count == COUNT_W'(1)) state <= ST_DONE;
      end
    end else if (res_ready) state <= ST_IDLE;
endmodule

// File: tb/tb_accumulator_ctrl.sv
// tb_accumulator_ctrl: directed vectors with hand-computed sums for accumulator_ctrl
module tb_accumulator_ctrl;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, res_ready = 0;
  logic [3:0] len = 0;
  logic [7:0] in_data = 0;
  logic in_ready, res_valid, busy, overflow;
  logic [7:0] acc_out;
  int passed = 0, total = 0;

  accumulator_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .acc_out(acc_out),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [3:0] l);
    start = 1; len = l;
    step;
    start = 0;
  endtask

  task automatic send(input logic [7:0] d);
    chk("in_ready_before_send", in_ready, 1);
    in_valid = 1; in_data = d;
    step;
    in_valid = 0; in_data = 'x;
  endtask

  task automatic take;
    chk("res_valid_before_take", res_valid, 1);
    res_ready = 1;
    step;
    res_ready = 0;
    chk("idle_after_take", busy, 0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_acc", acc_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_overflow", overflow, 0);
    rst = 0;
    step;
    // 1: three back-to-back operands
    do_start(3);
    chk("t1_busy", busy, 1);
    send(10);
    chk("t1_acc1", acc_out, 10);
    send(20);
    chk("t1_acc2", acc_out, 30);
    send(30);
    chk("t1_sum", acc_out, 60);
    chk("t1_ovf", overflow, 0);
    chk("t1_in_ready_done", in_ready, 0);
    take;
    chk("t1_retained", acc_out, 60);
    // 2: overflow then a clean run
    do_start(2);
    chk("t2_clear", acc_out, 0);
    send(200);
    send(100);
    chk("t2_sum", acc_out, 44);
    chk("t2_ovf", overflow, 1);
    take;
    chk("t2_ovf_retained", overflow, 1);
    do_start(1);
    chk("t2_ovf_cleared", overflow, 0);
    send(5);
    chk("t2b_sum", acc_out, 5);
    chk("t2b_ovf", overflow, 0);
    take;
    // 3: operand gaps and a slow consumer
    do_start(3);
    send(50);
    for (int i = 0; i < 2; i++) begin step; chk("t3_gap_hold", acc_out, 50); end
    send(60);
    for (int i = 0; i < 2; i++) begin step; chk("t3_gap_hold2", acc_out, 110); end
    send(70);
    in_valid = 1; in_data = 99;
    for (int i = 0; i < 5; i++) begin
      chk("t3_wait_valid", res_valid, 1);
      chk("t3_wait_acc", acc_out, 180);
      chk("t3_wait_in_ready", in_ready, 0);
      step;
    end
    in_valid = 0;
    take;
    // 4: zero-length run
    do_start(0);
    chk("t4_res_valid", res_valid, 1);
    chk("t4_acc", acc_out, 0);
    chk("t4_busy", busy, 1);
    take;
    // 5: async reset mid-run
    do_start(4);
    send(9);
    chk("t5_partial", acc_out, 9);
    #1 rst = 1;
    #1;
    chk("t5_rst_acc", acc_out, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 0;
    step;
    do_start(1);
    send(7);
    chk("t5_sum", acc_out, 7);
    take;
    // 6: start ignored while busy
    do_start(2);
    start = 1; len = 5;
    send(11);
    send(22);
    chk("t6_sum", acc_out, 33);
    step;
    chk("t6_done_hold", res_valid, 1);
    chk("t6_done_acc", acc_out, 33);
    start = 0;
    take;
    // start accepted in the first IDLE cycle after the handshake
    do_start(1);
    chk("t6_restart", in_ready, 1);
    send(4);
    chk("t6_restart_sum", acc_out, 4);
    take;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
